spi_arbiter: RTL and testbench

Round-robin arbiter and transaction sequencer sharing the SPI master among four requesters. Requester i always targets slave i: on grant the block drives the SPI subsystem's slave select and master data word, pulses tx_start, waits for tx_end and returns the received word to the granted requester. It sits between the requester logic and the SPI master/slave subsystem inputs (tx_start, sel, master_data_in, tx_end, master_data_out). The transaction timeout guards against a hung transfer.

---
 rtl/spi_arbiter.sv | 141 ++++++++++++++
 tb/tb_spi_arbiter.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/spi_arbiter.sv
// Round-robin arbiter sharing one SPI master among four requesters; requester i talks to slave i.
// Grants latch the request word, start the transfer, and return the received word or a timeout.
module spi_arbiter #(
   parameter int bits_num = 8,
   parameter int TIMEOUT  = 255
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [3:0]              req,
   input  logic [4*bits_num-1:0]   req_data,
   output logic [3:0]              gnt,
   output logic [3:0]              rsp_valid,
   output logic                    rsp_err,
   output logic [bits_num-1:0]     rsp_data,
   output logic                    busy,
   output logic                    spi_tx_start,
   output logic [1:0]              spi_sel,
   output logic [bits_num-1:0]     spi_data,
   input  logic                    spi_tx_end,
   input  logic [bits_num-1:0]     spi_rx_data
);

   localparam int CW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, START, WAIT, DONE} state_t;

   state_t              state_q, state_d;
   logic [1:0]          last_q, last_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic                tx_end_q, tx_end_d;
   logic [3:0]          gnt_q, gnt_d;
   logic [3:0]          rsp_valid_q, rsp_valid_d;
   logic                rsp_err_q, rsp_err_d;
   logic [bits_num-1:0] rsp_data_q, rsp_data_d;
   logic                busy_q, busy_d;
   logic                tx_start_q, tx_start_d;
   logic [1:0]          sel_q, sel_d;
   logic [bits_num-1:0] data_q, data_d;
   logic [1:0]          win;

   // Search last+1, last+2, ... ; k=4 wraps back onto last itself.
   always_comb begin
      logic [1:0] idx;
      logic       found;
      idx   = '0;
      found = 1'b0;
      win   = last_q;
      for (int k = 1; k <= 4; k++) begin
         idx = last_q + 2'(k);
         if (!found && req[idx]) begin
            win   = idx;
            found = 1'b1;
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      last_d      = last_q;
      cnt_d       = cnt_q;
      tx_end_d    = spi_tx_end;
      gnt_d       = '0;
      rsp_valid_d = '0;
      rsp_err_d   = 1'b0;
      rsp_data_d  = rsp_data_q;
      tx_start_d  = 1'b0;
      sel_d       = sel_q;
      data_d      = data_q;
      case (state_q)
         IDLE: if (req != 4'b0000) begin
            data_d  = req_data[win*bits_num +: bits_num];
            sel_d   = win;
            last_d  = win;
            gnt_d   = 4'(1) << win;
            state_d = START;
         end
         START: begin
            tx_start_d = 1'b1;
            cnt_d      = '0;
            state_d    = WAIT;
         end
         WAIT: begin
            // A real completion wins over a timeout landing on the same cycle.
            if (spi_tx_end && !tx_end_q) begin
               rsp_data_d  = spi_rx_data;
               rsp_valid_d = 4'(1) << sel_q;
               state_d     = DONE;
            end else if (cnt_q == CW'(TIMEOUT)) begin
               rsp_valid_d = 4'(1) << sel_q;
               rsp_err_d   = 1'b1;
               state_d     = DONE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         DONE: if (!spi_tx_end) state_d = IDLE;
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         last_q      <= 2'd3;
         cnt_q       <= '0;
         tx_end_q    <= 1'b0;
         gnt_q       <= '0;
         rsp_valid_q <= '0;
         rsp_err_q   <= 1'b0;
         rsp_data_q  <= '0;
         busy_q      <= 1'b0;
         tx_start_q  <= 1'b0;
         sel_q       <= '0;
         data_q      <= '0;
      end else begin
         state_q     <= state_d;
         last_q      <= last_d;
         cnt_q       <= cnt_d;
         tx_end_q    <= tx_end_d;
         gnt_q       <= gnt_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_err_q   <= rsp_err_d;
         rsp_data_q  <= rsp_data_d;
         busy_q      <= busy_d;
         tx_start_q  <= tx_start_d;
         sel_q       <= sel_d;
         data_q      <= data_d;
      end
   end

   assign gnt          = gnt_q;
   assign rsp_valid    = rsp_valid_q;
   assign rsp_err      = rsp_err_q;
   assign rsp_data     = rsp_data_q;
   assign busy         = busy_q;
   assign spi_tx_start = tx_start_q;
   assign spi_sel      = sel_q;
   assign spi_data     = data_q;

endmodule

// File: tb/tb_spi_arbiter.sv
// Directed + randomized bench for spi_arbiter with a transaction-level round-robin model.
module tb_spi_arbiter;
   localparam int BN = 8;
   localparam int TO = 16;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic [3:0]      req = '0;
   logic [4*BN-1:0] req_data = '0;
   logic            spi_tx_end = 1'b0;
   logic [BN-1:0]   spi_rx_data = '0;
   logic [3:0]      gnt, rsp_valid;
   logic            rsp_err, busy, spi_tx_start;
   logic [BN-1:0]   rsp_data, spi_data;
   logic [1:0]      spi_sel;

   int n_cmp = 0;
   int n_err = 0;
   int m_last = 3;
   logic [BN-1:0] m_rsp = '0;

   spi_arbiter #(.bits_num(BN), .TIMEOUT(TO)) dut (
      .clk(clk), .reset(rst_n), .req(req), .req_data(req_data),
      .gnt(gnt), .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_data(rsp_data),
      .busy(busy), .spi_tx_start(spi_tx_start), .spi_sel(spi_sel), .spi_data(spi_data),
      .spi_tx_end(spi_tx_end), .spi_rx_data(spi_rx_data)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Round-robin: first requester found scanning last+1 .. last+4 (mod 4).
   function automatic int pick(input logic [3:0] rq, input int last);
      for (int k = 1; k <= 4; k++)
         if (rq[(last + k) % 4]) return (last + k) % 4;
      return 0;
   endfunction

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_gnt"}, 32'(gnt), 0);
      chk({tag, "_rspv"}, 32'(rsp_valid), 0);
      chk({tag, "_rsperr"}, 32'(rsp_err), 0);
      chk({tag, "_rspdata"}, 32'(rsp_data), 0);
      chk({tag, "_busy"}, 32'(busy), 0);
      chk({tag, "_txstart"}, 32'(spi_tx_start), 0);
      chk({tag, "_sel"}, 32'(spi_sel), 0);
      chk({tag, "_data"}, 32'(spi_data), 0);
   endtask

   // Request in cycle T; checks gnt at T+1 and tx_start at T+2; returns in the tx_start cycle.
   task automatic start_txn(input logic [3:0] rq, input logic [31:0] d, output int w);
      req = rq;
      req_data = d;
      w = pick(rq, m_last);
      m_last = w;
      tick();
      chk("gnt", 32'(gnt), 32'(1) << w);
      chk("busy_at_gnt", 32'(busy), 1);
      chk("sel", 32'(spi_sel), 32'(w));
      chk("spi_data", 32'(spi_data), 32'(d[w*BN +: BN]));
      chk("start_early", 32'(spi_tx_start), 0);
      req[w] = 1'b0;
      tick();
      chk("tx_start", 32'(spi_tx_start), 1);
      chk("gnt_once", 32'(gnt), 0);
   endtask

   task automatic finish_txn(input int w, input int lat, input bit hang, input int hold,
                             input logic [BN-1:0] rx, input logic [31:0] d);
      if (hang) begin
         for (int c = 1; c <= TO; c++) begin
            tick();
            chk("rspv_early_to", 32'(rsp_valid), 0);
            chk("busy_wait", 32'(busy), 1);
            chk("gnt_busy", 32'(gnt), 0);
         end
         tick();
         chk("rspv_to", 32'(rsp_valid), 32'(1) << w);
         chk("rsperr_to", 32'(rsp_err), 1);
         chk("rspdata_kept", 32'(rsp_data), 32'(m_rsp));
      end else begin
         for (int c = 0; c < lat; c++) begin
            tick();
            chk("rspv_early", 32'(rsp_valid), 0);
            chk("txstart_once", 32'(spi_tx_start), 0);
            chk("sel_stable", 32'(spi_sel), 32'(w));
         end
         spi_tx_end = 1'b1;
         spi_rx_data = rx;
         tick();
         chk("rspv", 32'(rsp_valid), 32'(1) << w);
         chk("rsperr", 32'(rsp_err), 0);
         chk("rspdata", 32'(rsp_data), 32'(rx));
         m_rsp = rx;
         spi_rx_data = BN'($urandom);
         for (int c = 0; c < hold; c++) begin
            tick();
            chk("busy_done", 32'(busy), 1);
            chk("rspv_done", 32'(rsp_valid), 0);
            chk("gnt_done", 32'(gnt), 0);
            chk("data_stable", 32'(spi_data), 32'(d[w*BN +: BN]));
         end
      end
      spi_tx_end = 1'b0;
      tick();
      chk("idle_busy", 32'(busy), 0);
      chk("idle_gnt", 32'(gnt), 0);
      chk("idle_rspv", 32'(rsp_valid), 0);
   endtask

   task automatic do_txn(input logic [3:0] rq, input logic [31:0] d, input int lat,
                         input bit hang, input int hold, input logic [BN-1:0] rx);
      int w;
      start_txn(rq, d, w);
      finish_txn(w, lat, hang, hold, rx, d);
   endtask

   initial begin
      int w;
      tick();
      tick();
      chk_reset_vals("rst");
      rst_n = 1'b1;
      tick();
      chk("idle_after_rst", 32'(busy), 0);

      // single request
      do_txn(4'b0001, 32'h000000A5, 3, 1'b0, 0, 8'h3C);

      // fairness: all four persistently requesting
      for (int i = 0; i < 6; i++)
         do_txn(4'b1111, $urandom, $urandom_range(1, 6), 1'b0, $urandom_range(0, 2), BN'($urandom));

      // timeout, then a normal transaction
      do_txn(4'b0010, $urandom, 0, 1'b1, 0, 8'h00);
      do_txn(4'b0100, $urandom, 4, 1'b0, 0, 8'h5A);

      // stale tx_end held for 20 cycles, next transfer needs a fresh edge
      do_txn(4'b1000, $urandom, 2, 1'b0, 20, 8'hC3);
      do_txn(4'b0001, $urandom, 5, 1'b0, 0, 8'h81);

      // priority rotation: last = 2, then 1011 -> 3, 0, 1
      do_txn(4'b0100, $urandom, 1, 1'b0, 0, 8'h11);
      do_txn(4'b1011, $urandom, 1, 1'b0, 0, 8'h22);
      do_txn(4'b0011, $urandom, 1, 1'b0, 0, 8'h33);
      do_txn(4'b0010, $urandom, 1, 1'b0, 0, 8'h44);

      // randomized mix
      for (int i = 0; i < 12; i++)
         do_txn(4'($urandom_range(1, 15)), $urandom, $urandom_range(1, 12),
                ($urandom_range(0, 7) == 0), $urandom_range(0, 3), BN'($urandom));

      // reset three cycles after tx_start
      start_txn(4'b0100, 32'h00DE0000, w);
      for (int c = 0; c < 3; c++) begin
         tick();
         chk("rspv_pre_rst", 32'(rsp_valid), 0);
      end
      rst_n = 1'b0;
      #1;
      chk_reset_vals("midrst");
      tick();
      chk("rspv_in_rst", 32'(rsp_valid), 0);
      rst_n = 1'b1;
      m_last = 3;
      m_rsp = '0;
      req = '0;
      tick();
      chk("rspv_after_rst", 32'(rsp_valid), 0);
      chk("busy_after_rst", 32'(busy), 0);
      do_txn(4'b1001, $urandom, 2, 1'b0, 0, 8'h77);
      do_txn(4'b1000, $urandom, 2, 1'b0, 0, 8'h66);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
